adc_chan_packer: RTL

//  Parametrised ADC capture front end feeding the ADC DMA AXI-Stream master.
//  - Packs samples from up to NUM_CH channels, selected by a channel mask, into DATA_W beats.
//  - Buffers beats in a FIFO and frames them into PKT_WORDS-beat packets.
//  - On FIFO overflow, discards input, drains, holds off, then restarts.
//  - Generalises the fixed 4-channel default_block ADC path.

---
 rtl/adc_chan_packer_if.sv | 14 +
 rtl/adc_chan_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_chan_packer_if.sv
// AXI-Stream beat channel from the ADC channel packer to the ADC DMA.
// The packer drives the master side. The DMA, or a testbench, drives the slave side.
interface adc_chan_packer_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              m_tuser;

    modport master (output m_tdata, m_tvalid, m_tlast, m_tuser, input m_tready);
    modport slave  (input m_tdata, m_tvalid, m_tlast, m_tuser, output m_tready);
endinterface

// File: rtl/adc_chan_packer.sv
// ADC capture front end.
// Packs the samples of the channels selected by the mask into DATA_W beats.
// Beats are buffered in a FIFO and framed into PKT_WORDS-beat packets.
// After a FIFO overflow the block discards input, drains the FIFO, waits, and then restarts.
// Optional feature macro: PPS_ALIGN_EN. It adds an ARM state that holds capture until a pps rising edge.
// resetn is asynchronous and active-high. This matches the surrounding codebase.
module adc_chan_packer #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_W   = 16,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 64,
    parameter int PKT_WORDS  = 256
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic [15:0]                overflow_wait,
    input  logic                       overflow_clr,
    input  logic                       adc_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
    input  logic                       pps,
    adc_chan_packer_if.master          m_axis,
    output logic                       overflow,
    output logic [63:0]                sample_idx
);
    localparam int LANES  = DATA_W / SAMPLE_W;
    localparam int EXT_IW = $clog2(2 * LANES);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BC_W   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int ENT_W  = DATA_W + 2;
    localparam int LAST_I = PKT_WORDS - 1;
    localparam logic [EXT_IW-1:0] LANES_X   = LANES[EXT_IW-1:0];
    localparam logic [BC_W-1:0]   LAST_BEAT = LAST_I[BC_W-1:0];
    localparam logic [AW:0]       DEPTH_X   = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef PPS_ALIGN_EN
        S_ARM,
`endif
        S_RUN,
        S_DROP,
        S_WAIT
    } state_t;

    state_t                         r_state;
    logic [NUM_CH-1:0]              r_mask;
    logic [LANES-1:0][SAMPLE_W-1:0] r_pack;
    logic [EXT_IW-1:0]              r_fill;
    logic [BC_W-1:0]                r_beat_cnt;
    logic [15:0]                    r_wait_cnt;
    logic                           r_tuser_pend;
    logic                           r_en_d;
    logic                           r_overflow;
    logic [63:0]                    r_sample_idx;

    logic [ENT_W-1:0]               r_mem [FIFO_DEPTH];
    logic [AW:0]                    r_wr_ptr;
    logic [AW:0]                    r_rd_ptr;
    logic [AW:0]                    r_occ;
    logic [DATA_W-1:0]              r_out_data;
    logic                           r_out_valid;
    logic                           r_out_last;
    logic                           r_out_user;

    logic [2*LANES-1:0][SAMPLE_W-1:0] w_ext;
    logic [EXT_IW-1:0]              w_pos;
    logic                           w_beat_done;
    logic                           w_full;
    logic                           w_push;
    logic                           w_push_last;
    logic [DATA_W-1:0]              w_push_data;
    logic                           w_ovf_set;
    logic                           w_mem_nempty;
    logic                           w_load;
    logic                           w_pop;
    logic                           w_en_rise;

`ifdef PPS_ALIGN_EN
    logic                           r_pps_d;
`else
    logic                           w_unused_pps;
    assign w_unused_pps = pps;
`endif

    assign w_en_rise = enable && !r_en_d;

    // Append the enabled channels, in ascending order, to the lanes after the current fill point.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves a latch behind.
        w_ext            = '0;
        w_ext[LANES-1:0] = r_pack;
        w_pos            = r_fill;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_mask[k]) begin
                w_ext[w_pos] = adc_data[k*SAMPLE_W +: SAMPLE_W];
                w_pos        = w_pos + 1'b1;
            end
        end
        w_beat_done = (w_pos >= LANES_X);
    end

    // Decide which beat, if any, enters the FIFO this cycle, and detect overflow.
    always_comb begin
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_push_data = r_pack;
        w_ovf_set   = 1'b0;
        if (r_state == S_RUN) begin
            if (!enable) begin
                // Flush the partial beat. Lanes above the fill point are already zero.
                w_push_last = 1'b1;
                w_push      = (r_fill != '0) && !w_full;
            end else if (adc_valid && w_beat_done) begin
                w_push_data = w_ext[LANES-1:0];
                w_push_last = (r_beat_cnt == LAST_BEAT);
                w_push      = !w_full;
                w_ovf_set   = w_full;
            end
        end
    end

    // The output register counts toward occupancy, so "full" means FIFO_DEPTH beats are in flight.
    assign w_full       = (r_occ == DEPTH_X);
    assign w_mem_nempty = (r_wr_ptr != r_rd_ptr);
    assign w_pop        = r_out_valid && m_axis.m_tready;
    assign w_load       = w_mem_nempty && (!r_out_valid || m_axis.m_tready);

    // Beat storage write port: {tuser, tlast, tdata}.
    // NOTE: the storage array is not reset. Resetting the pointers is enough to flush it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {r_tuser_pend, w_push_last, w_push_data};
        end
    end

    // FIFO pointers, occupancy and the registered AXIS output stage.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_user  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr                               <= r_rd_ptr + 1'b1;
                {r_out_user, r_out_last, r_out_data}   <= r_mem[r_rd_ptr[AW-1:0]];
                r_out_valid                            <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            r_occ <= r_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Capture control: start, lane packing, packet count, overflow recovery and sample index.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_pack       <= '0;
            r_fill       <= '0;
            r_beat_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_tuser_pend <= 1'b0;
            r_en_d       <= 1'b0;
            r_overflow   <= 1'b0;
            r_sample_idx <= '0;
`ifdef PPS_ALIGN_EN
            r_pps_d      <= 1'b0;
`endif
        end else begin
            r_en_d <= enable;
`ifdef PPS_ALIGN_EN
            r_pps_d <= pps;
`endif
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_push) begin
                r_beat_cnt   <= w_push_last ? '0 : r_beat_cnt + 1'b1;
                r_tuser_pend <= 1'b0;
            end
            if (adc_valid && (r_state inside {S_RUN, S_DROP, S_WAIT})) begin
                r_sample_idx <= r_sample_idx + 64'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_en_rise) begin
                        r_mask       <= ch_mask;
                        r_sample_idx <= '0;
                        r_pack       <= '0;
                        r_fill       <= '0;
                        r_beat_cnt   <= '0;
                        r_tuser_pend <= 1'b0;
`ifdef PPS_ALIGN_EN
                        r_state      <= S_ARM;
`else
                        r_state      <= S_RUN;
`endif
                    end
                end
`ifdef PPS_ALIGN_EN
                S_ARM: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (pps && !r_pps_d) begin
                        r_sample_idx <= '0;
                        r_state      <= S_RUN;
                    end
                end
`endif
                S_RUN: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (adc_valid) begin
                        if (w_ovf_set) begin
                            r_state <= S_DROP;
                        end else if (w_beat_done) begin
                            r_pack <= w_ext[2*LANES-1:LANES];
                            r_fill <= w_pos - LANES_X;
                        end else begin
                            r_pack <= w_ext[LANES-1:0];
                            r_fill <= w_pos;
                        end
                    end
                end
                S_DROP: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (r_occ == '0) begin
                        r_wait_cnt <= overflow_wait;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (r_wait_cnt == '0) begin
                        r_pack       <= '0;
                        r_fill       <= '0;
                        r_beat_cnt   <= '0;
                        r_tuser_pend <= 1'b1;
                        r_state      <= S_RUN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axis.m_tdata  = r_out_data;
    assign m_axis.m_tvalid = r_out_valid;
    assign m_axis.m_tlast  = r_out_last;
    assign m_axis.m_tuser  = r_out_user;
    assign overflow        = r_overflow;
    assign sample_idx      = r_sample_idx;
endmodule
